proj_trigger_seq: RTL and testbench

//  Multi-channel projector trigger sequencer in the CLK_HS domain; successor to the single-output trigger logic in the exposure FSM.

---
 rtl/proj_trig_pkg.sv | 27 ++
 rtl/proj_trig_chan.sv | 125 ++++++++++++
 rtl/proj_trigger_seq.sv | 150 +++++++++++++++
 tb/tb_proj_trigger_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_trig_pkg.sv
// Shared definitions for the projector trigger sequencer.
//   chan_state_e    : one-hot channel state encoding (IDLE, COUNT, PULSE, DONE)
//   LOAD_CYCLES_DEF : CLK_HS cycles per full mask load (160 rows x 18)
//   lead_count()    : countdown start value for a channel, saturating at 0
package proj_trig_pkg;

    typedef enum logic [3:0] {
        CH_IDLE  = 4'b0001,
        CH_COUNT = 4'b0010,
        CH_PULSE = 4'b0100,
        CH_DONE  = 4'b1000
    } chan_state_e;

    localparam int LOAD_CYCLES_DEF = 2880;

    // Cycles to wait after window start so the pulse lands 'delay' cycles
    // before the end of the mask load. A lead time longer than the load
    // itself fires as early as possible instead of wrapping.
    function automatic int unsigned lead_count(input int unsigned load,
                                               input int unsigned delay);
        if (delay >= load) begin
            return 0;
        end
        return load - delay;
    endfunction

endpackage

// File: rtl/proj_trig_chan.sv
// One trigger channel of the projector trigger sequencer.
// Ports:
//   clk_i        fast clock (CLK_HS)
//   rst_i        synchronous active-high reset
//   stream_i     synchronised mask-load window
//   subc_i       synchronised subscene-active level
//   win_start_i  one-cycle pulse at the rising edge of stream_i
//   start_i      window start qualified by ARM / MODE / channel enable
//   delay_i      lead time before load end (sampled on COUNT entry)
//   width_i      pulse width, 0 treated as 1 (sampled on PULSE entry)
//   trig_o       trigger output, high while in PULSE
//   busy_o       channel not IDLE
//   entry_o      this cycle moves COUNT -> PULSE
//   overrun_o    window started while pulsing or done
//   missed_o     window ended before the countdown could fire
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a qualified window start
// COUNT | counting down the lead time, then waiting for subc_i
// PULSE | driving the trigger for the sampled width
// DONE  | pulse finished, waiting for the window to close
module proj_trig_chan
    import proj_trig_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int LOAD_CYCLES = LOAD_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stream_i,
    input  logic             subc_i,
    input  logic             win_start_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    output logic             trig_o,
    output logic             busy_o,
    output logic             entry_o,
    output logic             overrun_o,
    output logic             missed_o
);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_init;
    logic [CNT_W-1:0] wcnt_init;

    assign cnt_init  = CNT_W'(lead_count(LOAD_CYCLES, 32'(delay_i)));
    assign wcnt_init = (width_i == '0) ? CNT_W'(1) : width_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        entry_o   = 1'b0;
        overrun_o = 1'b0;
        missed_o  = 1'b0;
        unique case (state_q)
            CH_IDLE: begin
                if (start_i) begin
                    state_d = CH_COUNT;
                    cnt_d   = cnt_init;
                end
            end
            CH_COUNT: begin
                if (!stream_i) begin
                    state_d  = CH_IDLE;
                    missed_o = 1'b1;
                end else if (cnt_q == '0) begin
                    // Countdown expired: hold here until the exposure FSM
                    // is in the subscene state.
                    if (subc_i) begin
                        state_d = CH_PULSE;
                        wcnt_d  = wcnt_init;
                        entry_o = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CH_PULSE, CH_DONE: begin
                if (win_start_i) begin
                    // A new window always wins: the old pulse is cut short.
                    overrun_o = 1'b1;
                    if (start_i) begin
                        state_d = CH_COUNT;
                        cnt_d   = cnt_init;
                    end else begin
                        state_d = CH_IDLE;
                    end
                end else if (state_q == CH_PULSE) begin
                    // Window closing does not truncate a pulse in progress.
                    if (wcnt_q == CNT_W'(1)) begin
                        state_d = CH_DONE;
                    end else begin
                        wcnt_d = wcnt_q - CNT_W'(1);
                    end
                end else if (!stream_i) begin
                    state_d = CH_IDLE;
                end
            end
            default: begin
                state_d = CH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign trig_o = (state_q == CH_PULSE);
    assign busy_o = (state_q != CH_IDLE);

endmodule

// File: rtl/proj_trigger_seq.sv
// Multi-channel projector trigger sequencer (CLK_HS domain).
// Fires one programmable pulse per enabled channel per mask-load window,
// placed a per-channel lead time before the end of the load.
// Ports:
//   CLK_HS        fast clock
//   RESET         synchronous active-high reset
//   STREAM        mask-load window (asynchronous, synchronised here)
//   SUBC_ACTIVE   subscene-active level (asynchronous, synchronised here)
//   ARM           triggers permitted only if high at window start
//   MODE          0 = every window, 1 = single shot until ARM rises again
//   CH_EN         per-channel enable
//   PROJ_DELAY    per-channel lead time, ch i at [i*CNT_W +: CNT_W]
//   PULSE_WIDTH   shared pulse width in cycles (0 treated as 1)
//   TRIGGER_PROJ  per-channel trigger outputs
//   TRIG_COUNT    number of windows in which at least one channel fired
//   OVERRUN       sticky: window started while a channel was pulsing/done
//   MISSED        sticky: window closed before a countdown fired
//   BUSY          any channel not idle
module proj_trigger_seq
    import proj_trig_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int CNT_W       = 32,
    parameter int LOAD_CYCLES = LOAD_CYCLES_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK_HS,
    input  logic                  RESET,
    input  logic                  STREAM,
    input  logic                  SUBC_ACTIVE,
    input  logic                  ARM,
    input  logic                  MODE,
    input  logic [N_CH-1:0]       CH_EN,
    input  logic [N_CH*CNT_W-1:0] PROJ_DELAY,
    input  logic [CNT_W-1:0]      PULSE_WIDTH,
    output logic [N_CH-1:0]       TRIGGER_PROJ,
    output logic [CNT_W-1:0]      TRIG_COUNT,
    output logic                  OVERRUN,
    output logic                  MISSED,
    output logic                  BUSY
);

    logic [SYNC_STAGES-1:0] stream_sync_q, stream_sync_d;
    logic [SYNC_STAGES-1:0] subc_sync_q, subc_sync_d;
    logic                   stream_s, subc_s;
    logic                   stream_s_d_q;
    logic                   win_start;
    logic                   arm_q, arm_rise;
    logic                   go;
    logic                   shot_done_q, shot_done_d;
    logic                   counted_q, counted_d;
    logic [CNT_W-1:0]       trig_count_q, trig_count_d;
    logic                   overrun_q, overrun_d;
    logic                   missed_q, missed_d;
    logic                   any_entry;

    logic [N_CH-1:0]        ch_start;
    logic [N_CH-1:0]        ch_trig;
    logic [N_CH-1:0]        ch_busy;
    logic [N_CH-1:0]        ch_entry;
    logic [N_CH-1:0]        ch_overrun;
    logic [N_CH-1:0]        ch_missed;

    assign stream_s  = stream_sync_q[SYNC_STAGES-1];
    assign subc_s    = subc_sync_q[SYNC_STAGES-1];
    assign win_start = stream_s & ~stream_s_d_q;
    assign arm_rise  = ARM & ~arm_q;
    assign go        = win_start & ARM & (~MODE | ~shot_done_q);
    assign ch_start  = {N_CH{go}} & CH_EN;
    assign any_entry = |ch_entry;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        proj_trig_chan #(
            .CNT_W       (CNT_W),
            .LOAD_CYCLES (LOAD_CYCLES)
        ) u_chan (
            .clk_i       (CLK_HS),
            .rst_i       (RESET),
            .stream_i    (stream_s),
            .subc_i      (subc_s),
            .win_start_i (win_start),
            .start_i     (ch_start[g]),
            .delay_i     (PROJ_DELAY[g*CNT_W +: CNT_W]),
            .width_i     (PULSE_WIDTH),
            .trig_o      (ch_trig[g]),
            .busy_o      (ch_busy[g]),
            .entry_o     (ch_entry[g]),
            .overrun_o   (ch_overrun[g]),
            .missed_o    (ch_missed[g])
        );
    end

    always_comb begin
        stream_sync_d = {stream_sync_q[SYNC_STAGES-2:0], STREAM};
        subc_sync_d   = {subc_sync_q[SYNC_STAGES-2:0], SUBC_ACTIVE};
        overrun_d     = overrun_q | (|ch_overrun);
        missed_d      = missed_q | (|ch_missed);
        counted_d     = counted_q;
        trig_count_d  = trig_count_q;
        shot_done_d   = shot_done_q;

        // Count a window once, on the first channel to start pulsing.
        if (win_start) begin
            counted_d = 1'b0;
        end
        if (any_entry && !counted_d) begin
            trig_count_d = trig_count_q + CNT_W'(1);
            counted_d    = 1'b1;
        end

        // A pulse firing in single-shot mode takes precedence over a
        // coincident ARM rising edge, so that shot is not lost.
        if (any_entry && MODE) begin
            shot_done_d = 1'b1;
        end else if (arm_rise) begin
            shot_done_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_HS) begin
        if (RESET) begin
            stream_sync_q <= '0;
            subc_sync_q   <= '0;
            stream_s_d_q  <= 1'b0;
            arm_q         <= 1'b0;
            shot_done_q   <= 1'b0;
            counted_q     <= 1'b0;
            trig_count_q  <= '0;
            overrun_q     <= 1'b0;
            missed_q      <= 1'b0;
        end else begin
            stream_sync_q <= stream_sync_d;
            subc_sync_q   <= subc_sync_d;
            stream_s_d_q  <= stream_s;
            arm_q         <= ARM;
            shot_done_q   <= shot_done_d;
            counted_q     <= counted_d;
            trig_count_q  <= trig_count_d;
            overrun_q     <= overrun_d;
            missed_q      <= missed_d;
        end
    end

    assign TRIGGER_PROJ = ch_trig;
    assign TRIG_COUNT   = trig_count_q;
    assign OVERRUN      = overrun_q;
    assign MISSED       = missed_q;
    assign BUSY         = |ch_busy;

endmodule

// File: tb/tb_proj_trigger_seq.sv
module tb_proj_trigger_seq;
    localparam int N_CH = 2;
    localparam int CNT_W = 5;
    localparam int LOAD_CYCLES = 20;
    localparam int SYNC_STAGES = 2;

    logic                  CLK_HS = 1'b0;
    logic                  RESET = 1'b1;
    logic                  STREAM = 1'b0;
    logic                  SUBC_ACTIVE = 1'b0;
    logic                  ARM = 1'b0;
    logic                  MODE = 1'b0;
    logic [N_CH-1:0]       CH_EN = '0;
    logic [N_CH*CNT_W-1:0] PROJ_DELAY = '0;
    logic [CNT_W-1:0]      PULSE_WIDTH = '0;
    logic [N_CH-1:0]       TRIGGER_PROJ;
    logic [CNT_W-1:0]      TRIG_COUNT;
    logic                  OVERRUN;
    logic                  MISSED;
    logic                  BUSY;

    proj_trigger_seq #(
        .N_CH(N_CH), .CNT_W(CNT_W), .LOAD_CYCLES(LOAD_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK_HS(CLK_HS), .RESET(RESET), .STREAM(STREAM), .SUBC_ACTIVE(SUBC_ACTIVE),
        .ARM(ARM), .MODE(MODE), .CH_EN(CH_EN), .PROJ_DELAY(PROJ_DELAY),
        .PULSE_WIDTH(PULSE_WIDTH), .TRIGGER_PROJ(TRIGGER_PROJ), .TRIG_COUNT(TRIG_COUNT),
        .OVERRUN(OVERRUN), .MISSED(MISSED), .BUSY(BUSY)
    );

    always #5 CLK_HS = ~CLK_HS;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Window-level view: a channel is either counting down a remaining lead
    // time, emitting a pulse with some cycles left, or holding after its pulse
    // until the window closes.
    bit m_ss[SYNC_STAGES];
    bit m_sub[SYNC_STAGES];
    bit m_ss_prev, m_arm_prev, m_shot, m_counted, m_ovr, m_miss;
    int m_count;
    bit m_counting[N_CH];
    int m_left[N_CH];
    int m_pulse[N_CH];
    bit m_hold[N_CH];

    task automatic model_step();
        bit ss, sub, ws, go, fired;
        int dly, lead, w;
        if (RESET) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                m_ss[s] = 1'b0;
                m_sub[s] = 1'b0;
            end
            m_ss_prev = 0; m_arm_prev = 0; m_shot = 0; m_counted = 0;
            m_ovr = 0; m_miss = 0; m_count = 0;
            for (int c = 0; c < N_CH; c++) begin
                m_counting[c] = 0; m_left[c] = 0; m_pulse[c] = 0; m_hold[c] = 0;
            end
            return;
        end
        ss = m_ss[SYNC_STAGES-1];
        sub = m_sub[SYNC_STAGES-1];
        ws = ss && !m_ss_prev;
        go = ws && ARM && (!MODE || !m_shot);
        fired = 0;
        w = (PULSE_WIDTH == 0) ? 1 : int'(PULSE_WIDTH);
        for (int c = 0; c < N_CH; c++) begin
            dly = int'(PROJ_DELAY[c*CNT_W +: CNT_W]);
            lead = (dly >= LOAD_CYCLES) ? 0 : LOAD_CYCLES - dly;
            if (ws && (m_pulse[c] > 0 || m_hold[c])) begin
                m_ovr = 1; m_pulse[c] = 0; m_hold[c] = 0;
                if (go && CH_EN[c]) begin
                    m_counting[c] = 1; m_left[c] = lead;
                end
            end else if (m_counting[c]) begin
                if (!ss) begin
                    m_counting[c] = 0; m_miss = 1;
                end else if (m_left[c] == 0) begin
                    if (sub) begin
                        m_counting[c] = 0; m_pulse[c] = w; fired = 1;
                    end
                end else begin
                    m_left[c]--;
                end
            end else if (m_pulse[c] > 0) begin
                m_pulse[c]--;
                if (m_pulse[c] == 0) m_hold[c] = 1;
            end else if (m_hold[c]) begin
                if (!ss) m_hold[c] = 0;
            end else if (go && CH_EN[c]) begin
                m_counting[c] = 1; m_left[c] = lead;
            end
        end
        if (ws) m_counted = 0;
        if (fired && !m_counted) begin
            m_count = (m_count + 1) % (1 << CNT_W);
            m_counted = 1;
        end
        if (fired && MODE) m_shot = 1;
        else if (ARM && !m_arm_prev) m_shot = 0;
        m_arm_prev = ARM;
        m_ss_prev = ss;
        for (int s = SYNC_STAGES-1; s > 0; s--) begin
            m_ss[s] = m_ss[s-1];
            m_sub[s] = m_sub[s-1];
        end
        m_ss[0] = STREAM;
        m_sub[0] = SUBC_ACTIVE;
    endtask

    initial forever begin
        @(posedge CLK_HS);
        model_step();
    end

    initial forever begin
        int exp_trig, exp_busy;
        @(negedge CLK_HS);
        if (cmp_en) begin
            exp_trig = 0;
            exp_busy = 0;
            for (int c = 0; c < N_CH; c++) begin
                if (m_pulse[c] > 0) exp_trig |= (1 << c);
                if (m_counting[c] || m_pulse[c] > 0 || m_hold[c]) exp_busy = 1;
            end
            check("model_trigger", int'(TRIGGER_PROJ), exp_trig);
            check("model_count", int'(TRIG_COUNT), m_count);
            check("model_overrun", int'(OVERRUN), int'(m_ovr));
            check("model_missed", int'(MISSED), int'(m_miss));
            check("model_busy", int'(BUSY), exp_busy);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK_HS);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
    endtask

    // STREAM high for 'hi' clock edges, then low for 'lo'; records the first
    // sample (edge index) each trigger is high and how many samples it is high.
    task automatic run_window(input int hi, input int lo,
                              output int r0, output int r1, output int w0, output int w1);
        r0 = -1; r1 = -1; w0 = 0; w1 = 0;
        STREAM = 1'b1;
        for (int k = 1; k <= hi + lo; k++) begin
            @(negedge CLK_HS);
            if (k == hi) STREAM = 1'b0;
            if (TRIGGER_PROJ[0]) begin
                if (r0 < 0) r0 = k;
                w0++;
            end
            if (TRIGGER_PROJ[1]) begin
                if (r1 < 0) r1 = k;
                w1++;
            end
        end
    endtask

    initial begin
        int r0, r1, w0, w1, first;
        tick(1);
        cmp_en = 1'b1;
        tick(1);
        RESET = 1'b0;
        check("reset_trigger", int'(TRIGGER_PROJ), 0);
        check("reset_count", int'(TRIG_COUNT), 0);
        check("reset_busy", int'(BUSY), 0);

        // Lead times 5 / 25 (saturated), width 3.
        ARM = 1; MODE = 0; CH_EN = 2'b11; SUBC_ACTIVE = 1;
        PROJ_DELAY = {5'd25, 5'd5}; PULSE_WIDTH = 5'd3;
        tick(3);
        run_window(30, 8, r0, r1, w0, w1);
        check("delay_ch0_rise", r0, 19);
        check("delay_ch1_rise", r1, 4);
        check("delay_ch0_width", w0, 3);
        check("delay_ch1_width", w1, 3);
        check("delay_count", int'(TRIG_COUNT), 1);
        check("delay_busy_end", int'(BUSY), 0);

        // Window too short for the countdown.
        CH_EN = 2'b01;
        run_window(8, 8, r0, r1, w0, w1);
        check("missed_no_pulse", w0, 0);
        check("missed_flag", int'(MISSED), 1);
        check("missed_busy_end", int'(BUSY), 0);

        // Subscene arrives long after the countdown; width 0 gives 1 cycle.
        do_reset();
        SUBC_ACTIVE = 0; STREAM = 1;
        tick(30);
        check("subc_wait_trig", int'(TRIGGER_PROJ), 0);
        check("subc_wait_busy", int'(BUSY), 1);
        PULSE_WIDTH = 5'd0; SUBC_ACTIVE = 1;
        first = -1; w0 = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK_HS);
            if (TRIGGER_PROJ[0]) begin
                if (first < 0) first = k;
                w0++;
            end
        end
        check("subc_rise", first, 3);
        check("width0_pulse", w0, 1);
        STREAM = 0;
        tick(6);
        check("subc_busy_end", int'(BUSY), 0);

        // Single shot.
        do_reset();
        MODE = 1; CH_EN = 2'b11; PROJ_DELAY = {5'd25, 5'd25}; PULSE_WIDTH = 5'd2;
        tick(2);
        run_window(6, 4, r0, r1, w0, w1);
        check("shot_first", w0, 2);
        run_window(6, 4, r0, r1, w0, w1);
        check("shot_second", w0 + w1, 0);
        run_window(6, 4, r0, r1, w0, w1);
        check("shot_third", w0 + w1, 0);
        ARM = 0; tick(2); ARM = 1; tick(2);
        run_window(6, 4, r0, r1, w0, w1);
        check("shot_rearm", w0, 2);
        check("shot_count", int'(TRIG_COUNT), 2);

        // Overrun: long pulse cut by the next window, then reset mid-pulse.
        do_reset();
        MODE = 0; CH_EN = 2'b01; PROJ_DELAY = {5'd0, 5'd25}; PULSE_WIDTH = 5'd31;
        tick(2);
        run_window(20, 5, r0, r1, w0, w1);
        check("ovr_first_rise", r0, 4);
        check("ovr_first_width", w0, 22);
        STREAM = 1;
        tick(3);
        check("ovr_truncated", int'(TRIGGER_PROJ), 0);
        check("ovr_flag", int'(OVERRUN), 1);
        tick(1);
        check("ovr_restart", int'(TRIGGER_PROJ), 1);
        check("ovr_count", int'(TRIG_COUNT), 2);
        tick(5);
        RESET = 1;
        tick(1);
        check("rst_trigger", int'(TRIGGER_PROJ), 0);
        check("rst_count", int'(TRIG_COUNT), 0);
        check("rst_overrun", int'(OVERRUN), 0);
        check("rst_busy", int'(BUSY), 0);
        RESET = 0; STREAM = 0;
        tick(3);

        // TRIG_COUNT wrap.
        PULSE_WIDTH = 5'd1;
        for (int i = 0; i < 31; i++) run_window(5, 4, r0, r1, w0, w1);
        check("wrap_before", int'(TRIG_COUNT), 31);
        run_window(5, 4, r0, r1, w0, w1);
        check("wrap_after", int'(TRIG_COUNT), 0);

        // Randomised windows against the model.
        for (int w = 0; w < 80; w++) begin
            int hi, lo;
            if ($urandom_range(0, 19) == 0) do_reset();
            ARM = ($urandom_range(0, 7) != 0);
            MODE = ($urandom_range(0, 3) == 0);
            CH_EN = N_CH'($urandom);
            PROJ_DELAY = (N_CH*CNT_W)'($urandom);
            PULSE_WIDTH = CNT_W'($urandom_range(0, 12));
            SUBC_ACTIVE = ($urandom_range(0, 3) != 0);
            hi = $urandom_range(3, 40);
            lo = $urandom_range(1, 12);
            STREAM = 1;
            for (int k = 1; k <= hi + lo; k++) begin
                @(negedge CLK_HS);
                if (k == hi) STREAM = 0;
                if ($urandom_range(0, 5) == 0) SUBC_ACTIVE = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 9) == 0) PROJ_DELAY = (N_CH*CNT_W)'($urandom);
                if ($urandom_range(0, 9) == 0) PULSE_WIDTH = CNT_W'($urandom_range(0, 31));
                if ($urandom_range(0, 9) == 0) CH_EN = N_CH'($urandom);
            end
        end
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
